counter_seq_checker: RTL
========================

COUNTER_SEQ_CHECKER -- requirements
Module: counter_seq_checker

Interface
REQ-001 The block SHALL have parameter LOCK_COUNT, default 2, meaning the number of consecutive in-sequence samples needed to declare lock (legal range 1-7).
REQ-002 The block SHALL have parameter MAX_MISS, default 2, meaning the number of consecutive mismatches in LOCKED that drops lock (legal range 1-7).
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port Valid, input, 1 bit: Data_in carries a counter sample this cycle.
REQ-006 The block SHALL have port Load, input, 1 bit: the observed counter was parallel-loaded this cycle; qualified by Valid.
REQ-007 The block SHALL have port Data_in, input, 4 bits: the counter's decoded output value.
REQ-008 The block SHALL have port Locked, output, 1 bit: high while the FSM is in LOCKED.
REQ-009 The block SHALL have port Mismatch, output, 1 bit: one-cycle pulse per mismatching sample in LOCKED.
REQ-010 The block SHALL have port Expected, output, 4 bits: code the next sample must carry.
REQ-011 The block SHALL have port Err_count, output, 8 bits: saturating count of mismatches since reset.
REQ-012 The block SHALL have port State_idx, output, 3 bits: table index (0-7) of Expected.

Function
REQ-013 The sequence table SHALL be fixed, in index order 0 to 7: 0x0, 0x3, 0x5, 0x6, 0x9, 0xA, 0xC, 0xF. Index 7 wraps to index 0.
REQ-014 A code SHALL count as "legal" only if it appears in the table. Decoding a code to its index SHALL be combinational.
REQ-015 The FSM SHALL have exactly three states: SEARCH, VERIFY and LOCKED. Cycles with Valid=0 SHALL change no state, counter or output, except that Mismatch returns low.
REQ-016 In SEARCH, a Valid legal sample SHALL set State_idx to idx+1 mod 8. It SHALL set the hit counter to 1 and move to VERIFY, or to LOCKED if LOCK_COUNT=1. A Valid illegal sample SHALL stay in SEARCH.
REQ-017 In VERIFY, a sample equal to Expected SHALL advance State_idx and increment the hit counter. When the hit counter reaches LOCK_COUNT, the FSM SHALL enter LOCKED on the same edge.
REQ-018 In VERIFY, a legal sample not equal to Expected SHALL re-seed: State_idx becomes idx+1 and the hit counter becomes 1. An illegal sample SHALL return the FSM to SEARCH.
REQ-019 In LOCKED, a sample equal to Expected SHALL advance State_idx and clear the miss counter.
REQ-020 In LOCKED, a sample not equal to Expected SHALL assert Mismatch on the next cycle, saturating-increment Err_count (holds at 0xFF), increment the miss counter, and still advance State_idx by 1.
REQ-021 In LOCKED, when the miss counter reaches MAX_MISS, the FSM SHALL go to SEARCH on that same edge, and Locked SHALL fall with it.
REQ-022 Valid with Load=1 SHALL be handled as follows in any state. If Data_in is legal: State_idx becomes idx+1, the current state is kept, the miss counter is cleared, and no Mismatch or error is recorded. If Data_in is illegal: in LOCKED it SHALL be treated as a mismatch per REQ-020/021; in other states it SHALL go to SEARCH.
REQ-023 Expected SHALL always equal the table entry at State_idx and SHALL be registered-path only: no combinational path from Data_in to Expected.
REQ-024 Locked, Mismatch, Err_count and State_idx SHALL be registered outputs. Latency from the sample edge to the output update SHALL be 1 cycle.

Reset
REQ-025 Reset=1 at a rising edge SHALL set: FSM=SEARCH, Locked=0, Mismatch=0, Err_count=0x00, State_idx=0, Expected=0x0, and the hit and miss counters to 0.
REQ-026 Reset SHALL take priority over Valid and Load in the same cycle. Reset mid-LOCKED SHALL discard all tracking; Err_count is not preserved.

Verification
REQ-027 Reset, then stream 0x0,0x3,0x5 with Valid=1 (defaults) -> Locked=1 after the 2nd sample's edge, Expected=0x5, Err_count=0.
REQ-028 Locked, then feed the wrap 0xC,0xF,0x0,0x3 -> no Mismatch, State_idx goes 6,7,0,1,2.
REQ-029 Locked with Expected=0x9, then feed 0x6 -> Mismatch pulse for 1 cycle, Err_count=1, Expected=0xA, Locked stays 1. Then feed 0x0 -> Err_count=2 and Locked=0 (SEARCH).
REQ-030 Locked with Expected=0x6, then Valid+Load with Data_in=0xC -> no Mismatch, Expected=0xF, Locked=1. Then Valid+Load with Data_in=0x4 -> Mismatch, Err_count+1.
REQ-031 Force 300 mismatches via repeated relock -> Err_count saturates at 0xFF. Then assert Reset -> all outputs return to REQ-025 values the next cycle.
REQ-032 In SEARCH, feed 0x1, 0x2 (illegal) -> stays SEARCH. Interleave Valid=0 cycles inside a locked stream -> no state change.

Source files
------------

// File: rtl/counter_seq_checker.sv
// Tracks a counter that should step through a fixed 8-entry code table and
// reports lock, per-sample mismatches and a saturating error count.
module counter_seq_checker #(
    parameter int unsigned LOCK_COUNT = 2,
    parameter int unsigned MAX_MISS   = 2
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Valid,
    input  logic       Load,
    input  logic [3:0] Data_in,
    output logic       Locked,
    output logic       Mismatch,
    output logic [3:0] Expected,
    output logic [7:0] Err_count,
    output logic [2:0] State_idx
);

    typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

    state_e     state_q;
    logic [2:0] hit_q;
    logic [2:0] miss_q;

    logic       legal;
    logic [2:0] din_idx;
    logic [2:0] din_next;
    logic [2:0] idx_adv;
    logic [2:0] hit_inc;
    logic [2:0] miss_inc;
    logic       match;
    logic [7:0] err_inc;

    function automatic logic [3:0] seq_code(input logic [2:0] i);
        logic [3:0] c;
        case (i)
            3'd0:    c = 4'h0;
            3'd1:    c = 4'h3;
            3'd2:    c = 4'h5;
            3'd3:    c = 4'h6;
            3'd4:    c = 4'h9;
            3'd5:    c = 4'hA;
            3'd6:    c = 4'hC;
            default: c = 4'hF;
        endcase
        return c;
    endfunction

    always_comb begin
        legal   = 1'b1;
        din_idx = 3'd0;
        case (Data_in)
            4'h0:    din_idx = 3'd0;
            4'h3:    din_idx = 3'd1;
            4'h5:    din_idx = 3'd2;
            4'h6:    din_idx = 3'd3;
            4'h9:    din_idx = 3'd4;
            4'hA:    din_idx = 3'd5;
            4'hC:    din_idx = 3'd6;
            4'hF:    din_idx = 3'd7;
            default: legal   = 1'b0;
        endcase
    end

    // Expected depends only on the registered index, never on Data_in.
    assign Expected = seq_code(State_idx);
    assign Locked   = (state_q == StLocked);

    assign din_next = din_idx + 3'd1;
    assign idx_adv  = State_idx + 3'd1;
    assign hit_inc  = hit_q + 3'd1;
    assign miss_inc = miss_q + 3'd1;
    assign match    = (Data_in == Expected);
    assign err_inc  = (Err_count == 8'hFF) ? 8'hFF : Err_count + 8'd1;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= StSearch;
            hit_q     <= 3'd0;
            miss_q    <= 3'd0;
            Mismatch  <= 1'b0;
            Err_count <= 8'h00;
            State_idx <= 3'd0;
        end else begin
            Mismatch <= 1'b0;
            if (Valid) begin
                if (Load && legal) begin
                    State_idx <= din_next;
                    miss_q    <= 3'd0;
                end else if (state_q == StLocked) begin
                    if (!Load && match) begin
                        State_idx <= idx_adv;
                        miss_q    <= 3'd0;
                    end else begin
                        Mismatch  <= 1'b1;
                        Err_count <= err_inc;
                        State_idx <= idx_adv;
                        if (miss_inc >= 3'(MAX_MISS)) begin
                            state_q <= StSearch;
                            miss_q  <= 3'd0;
                            hit_q   <= 3'd0;
                        end else begin
                            miss_q <= miss_inc;
                        end
                    end
                end else if (Load || !legal) begin
                    state_q <= StSearch;
                    hit_q   <= 3'd0;
                end else if (state_q == StVerify && match) begin
                    State_idx <= idx_adv;
                    hit_q     <= hit_inc;
                    if (hit_inc >= 3'(LOCK_COUNT)) begin
                        state_q <= StLocked;
                        miss_q  <= 3'd0;
                    end
                end else begin
                    // Legal sample seeds tracking from SEARCH or re-seeds in VERIFY.
                    State_idx <= din_next;
                    hit_q     <= 3'd1;
                    miss_q    <= 3'd0;
                    state_q   <= (LOCK_COUNT <= 1) ? StLocked : StVerify;
                end
            end
        end
    end

endmodule
